// File: rtl/instr_encode.sv
// RV32I instruction encoder: packs a field bundle into a 32-bit word with
// immediate range checks, then queues {word, error} in a small output FIFO.
module instr_encode #(
    parameter int DEPTH = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  format,
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [4:0]  rd,
    input  logic [31:0] immediate,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instruction,
    output logic        out_error,
    output logic [15:0] encoded_count,
    output logic [15:0] error_count
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [31:0] NOP_WORD = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] word;
        logic        err;
    } entry_t;

    logic [31:0] imm;
    logic [31:0] enc_word;
    logic        bad;
    entry_t      enc_entry;

    entry_t         mem [DEPTH];
    logic [PW-1:0]  wr_ptr, rd_ptr;
    logic [CW-1:0]  occupancy;
    logic           push, pop;
    entry_t         head;

    assign imm = immediate;

    // A sign-extended immediate fits when the bits above its top bit all
    // match that top bit; the range checks below compare imm[31:msb].
    always_comb begin
        enc_word = '0;
        bad      = 1'b0;
        case (format)
            3'd0: enc_word = {funct7, rs2, rs1, funct3, rd, opcode};
            3'd1: begin
                enc_word = {imm[11:0], rs1, funct3, rd, opcode};
                bad      = !((&imm[31:11]) || !(|imm[31:11]));
            end
            3'd2: begin
                enc_word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
                bad      = !((&imm[31:11]) || !(|imm[31:11]));
            end
            3'd3: begin
                enc_word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
                bad      = !((&imm[31:12]) || !(|imm[31:12])) || imm[0];
            end
            3'd4: begin
                enc_word = {imm[31:12], rd, opcode};
                bad      = |imm[11:0];
            end
            3'd5: begin
                enc_word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
                bad      = !((&imm[31:20]) || !(|imm[31:20])) || imm[0];
            end
            default: bad = 1'b1;
        endcase
        if (opcode[1:0] != 2'b11) bad = 1'b1;
        enc_entry.word = bad ? NOP_WORD : enc_word;
        enc_entry.err  = bad;
    end

    // in_ready looks only at registered occupancy, so a full FIFO blocks the
    // push even when a pop happens on the same edge.
    assign in_ready  = (occupancy < CW'(DEPTH)) && !reset;
    assign out_valid = (occupancy != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign head      = mem[rd_ptr];

    assign out_instruction = out_valid ? head.word : 32'h0;
    assign out_error       = out_valid ? head.err  : 1'b0;

    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr] <= enc_entry;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occupancy <= '0;
        end else begin
            if (push) wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
            if (pop)  rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   occupancy <= occupancy + CW'(1);
                2'b01:   occupancy <= occupancy - CW'(1);
                default: occupancy <= occupancy;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            encoded_count <= '0;
            error_count   <= '0;
        end else if (pop) begin
            if (encoded_count != 16'hFFFF) encoded_count <= encoded_count + 16'd1;
            if (head.err && error_count != 16'hFFFF) error_count <= error_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_instr_encode.sv
// Bench for instr_encode: vector table plus scoreboard queue, with
// hand-written backpressure, streaming and mid-stream reset sequences.
module tb_instr_encode;
    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  format;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] immediate;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instruction;
    logic        out_error;
    logic [15:0] encoded_count;
    logic [15:0] error_count;

    instr_encode #(.DEPTH(2)) dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .format(format), .opcode(opcode), .funct3(funct3), .funct7(funct7),
        .rs1(rs1), .rs2(rs2), .rd(rd), .immediate(immediate),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instruction(out_instruction), .out_error(out_error),
        .encoded_count(encoded_count), .error_count(error_count)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [2:0]  fmt;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [4:0]  s1, s2, d;
        logic [31:0] imm;
        logic [31:0] exp_word;
        logic        exp_err;
    } vec_t;

    typedef struct {
        logic [31:0] word;
        logic        err;
    } exp_t;

    vec_t  vecs [15];
    exp_t  sb [$];
    int    errors = 0;
    int    checks = 0;
    int    cyc = 0;
    int    n_pops = 0;
    int    n_err_pops = 0;
    int    last_acc = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Called aligned to a falling edge; returns on the next falling edge
    // after the bundle is accepted.
    task automatic send(input vec_t v);
        bit acc = 0;
        in_valid  = 1'b1;
        format    = v.fmt;
        opcode    = v.op;
        funct3    = v.f3;
        funct7    = v.f7;
        rs1       = v.s1;
        rs2       = v.s2;
        rd        = v.d;
        immediate = v.imm;
        for (int t = 0; t < 20 && !acc; t++) begin
            #4;
            if (in_ready) begin
                sb.push_back('{word: v.exp_word, err: v.exp_err});
                last_acc = cyc + 1;
                acc = 1;
            end
            @(negedge clock);
        end
        in_valid = 1'b0;
        if (!acc) begin
            errors++;
            checks++;
            $display("FAIL send_timeout: got in_ready=0 want accept within 20 cycles");
        end
    endtask

    task automatic drain();
        bit done = 0;
        for (int t = 0; t < 40 && !done; t++) begin
            @(negedge clock);
            if (sb.size() == 0 && !out_valid) done = 1;
        end
        if (!done) begin
            errors++;
            checks++;
            $display("FAIL drain_timeout: got %0d queued want 0", sb.size());
        end
    endtask

    // Monitor: the head must match the scoreboard front on every cycle it is
    // valid (which also proves stability while stalled); pop on handshake.
    always begin
        @(negedge clock);
        #4;
        if (out_valid) begin
            if (sb.size() == 0) begin
                errors++;
                checks++;
                $display("FAIL stale_word: got %h want no output", out_instruction);
            end else begin
                chk("head_word", out_instruction, sb[0].word);
                chk("head_err", {31'd0, out_error}, {31'd0, sb[0].err});
                if (out_ready) begin
                    n_pops++;
                    if (sb[0].err) n_err_pops++;
                    void'(sb.pop_front());
                end
            end
        end
    end

    function automatic vec_t mk(input logic [2:0] fmt, input logic [6:0] op, input logic [2:0] f3,
                                input logic [6:0] f7, input logic [4:0] s1, input logic [4:0] s2,
                                input logic [4:0] d, input logic [31:0] imm,
                                input logic [31:0] w, input logic e);
        vec_t v;
        v.fmt = fmt; v.op = op; v.f3 = f3; v.f7 = f7; v.s1 = s1; v.s2 = s2; v.d = d;
        v.imm = imm; v.exp_word = w; v.exp_err = e;
        return v;
    endfunction

    initial begin
        int exp_acc;
        int first_acc;
        vec_t v;

        vecs[0]  = mk(3'd1, 7'h13, 3'd0, 7'h00, 5'd0, 5'd0, 5'd1, 32'd5,        32'h0050_0093, 1'b0);
        vecs[1]  = mk(3'd0, 7'h33, 3'd0, 7'h00, 5'd1, 5'd2, 5'd3, 32'd0,        32'h0020_81B3, 1'b0);
        vecs[2]  = mk(3'd2, 7'h23, 3'd2, 7'h00, 5'd1, 5'd2, 5'd0, 32'd8,        32'h0020_A423, 1'b0);
        vecs[3]  = mk(3'd3, 7'h63, 3'd0, 7'h00, 5'd1, 5'd2, 5'd0, -32'sd4,      32'hFE20_8EE3, 1'b0);
        vecs[4]  = mk(3'd5, 7'h6F, 3'd0, 7'h00, 5'd0, 5'd0, 5'd1, 32'h800,      32'h0010_00EF, 1'b0);
        vecs[5]  = mk(3'd4, 7'h37, 3'd0, 7'h00, 5'd0, 5'd0, 5'd5, 32'h1234_5000, 32'h1234_52B7, 1'b0);
        vecs[6]  = mk(3'd1, 7'h13, 3'd0, 7'h00, 5'd0, 5'd0, 5'd1, 32'd2048,     32'h0000_0013, 1'b1);
        vecs[7]  = mk(3'd3, 7'h63, 3'd0, 7'h00, 5'd1, 5'd2, 5'd0, 32'd3,        32'h0000_0013, 1'b1);
        vecs[8]  = mk(3'd7, 7'h13, 3'd0, 7'h00, 5'd1, 5'd2, 5'd3, 32'd0,        32'h0000_0013, 1'b1);
        vecs[9]  = mk(3'd4, 7'h37, 3'd0, 7'h00, 5'd0, 5'd0, 5'd5, 32'h1,        32'h0000_0013, 1'b1);
        vecs[10] = mk(3'd1, 7'h10, 3'd0, 7'h00, 5'd0, 5'd0, 5'd1, 32'd5,        32'h0000_0013, 1'b1);
        vecs[11] = mk(3'd1, 7'h13, 3'd0, 7'h00, 5'd0, 5'd0, 5'd1, -32'sd2048,   32'h8000_0093, 1'b0);
        vecs[12] = mk(3'd5, 7'h6F, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0, -32'sd2,      32'hFFFF_F06F, 1'b0);
        vecs[13] = mk(3'd1, 7'h13, 3'd0, 7'h00, 5'd0, 5'd0, 5'd1, 32'd2047,     32'h7FF0_0093, 1'b0);
        vecs[14] = mk(3'd2, 7'h23, 3'd2, 7'h00, 5'd1, 5'd2, 5'd0, -32'sd2049,   32'h0000_0013, 1'b1);

        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        format = '0; opcode = '0; funct3 = '0; funct7 = '0;
        rs1 = '0; rs2 = '0; rd = '0; immediate = '0;
        repeat (2) @(negedge clock);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_instr", out_instruction, 32'd0);
        chk("rst_out_error", {31'd0, out_error}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_enc_count", {16'd0, encoded_count}, 32'd0);
        chk("rst_err_count", {16'd0, error_count}, 32'd0);
        reset = 1'b0;
        #1 chk("in_ready_after_rst", {31'd0, in_ready}, 32'd1);
        @(negedge clock);

        // Latency: word visible the cycle after acceptance.
        out_ready = 1'b1;
        send(vecs[0]);
        chk("latency_valid", {31'd0, out_valid}, 32'd1);
        drain();
        chk("enc_count_first", {16'd0, encoded_count}, 32'd1);

        // Error I-type alone so error_count reaches exactly 1.
        send(vecs[6]);
        drain();
        chk("err_count_first", {16'd0, error_count}, 32'd1);

        for (int i = 0; i < 15; i++) send(vecs[i]);
        drain();
        chk("enc_count_table", {16'd0, encoded_count}, n_pops);
        chk("err_count_table", {16'd0, error_count}, n_err_pops);

        // Backpressure: two fill the FIFO, the third waits for the first pop.
        out_ready = 1'b0;
        send(vecs[1]);
        send(vecs[2]);
        exp_acc = 0;
        fork
            send(vecs[3]);
            begin
                repeat (2) begin
                    #4 chk("full_in_ready", {31'd0, in_ready}, 32'd0);
                    @(negedge clock);
                end
                out_ready = 1'b1;
                exp_acc = cyc + 2;
            end
        join
        chk("third_accept_cycle", last_acc, exp_acc);
        drain();

        // Streaming: back-to-back accepts, one per cycle.
        for (int i = 0; i < 100; i++) begin
            v = mk(3'd1, 7'h13, 3'd0, 7'h00, 5'd0, 5'd0, 5'(i), 32'(i),
                   {12'(i), 5'd0, 3'd0, 5'(i), 7'h13}, 1'b0);
            send(v);
            if (i == 0) first_acc = last_acc;
        end
        chk("stream_cycles", last_acc - first_acc, 99);
        drain();
        chk("enc_count_stream", {16'd0, encoded_count}, n_pops);

        // Reset with two entries queued.
        out_ready = 1'b0;
        send(vecs[4]);
        send(vecs[5]);
        #2 reset = 1'b1;
        #1;
        chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst_enc_count", {16'd0, encoded_count}, 32'd0);
        chk("midrst_err_count", {16'd0, error_count}, 32'd0);
        chk("midrst_in_ready", {31'd0, in_ready}, 32'd0);
        sb.delete();
        n_pops = 0;
        n_err_pops = 0;
        @(negedge clock);
        reset = 1'b0;
        #4 chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
        out_ready = 1'b1;
        @(negedge clock);
        repeat (4) @(negedge clock);
        chk("post_rst_out_valid", {31'd0, out_valid}, 32'd0);
        send(vecs[2]);
        drain();
        chk("post_rst_enc_count", {16'd0, encoded_count}, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish want finish");
        $fatal(1);
    end
endmodule

// File: doc/instr_encode.md
# instr_encode

RV32I instruction encoder: the inverse of the field decoder. It accepts instruction fields plus a format selector over a valid/ready handshake, range-checks the immediate, and packs the fields into a 32-bit instruction word. Results are buffered in a small output FIFO with its own valid/ready handshake. It sits on the test/stimulus side of the ALU datapath and feeds instruction words to the decode/execute path.

## Interface
- DEPTH, 2, output FIFO entries (power of two, ≥2)
- clock  input  1  sole clock, rising edge
- reset  input  1  asynchronous, active-high
- in_valid  input  1  field bundle valid
- in_ready  output  1  encoder can accept a bundle
- format  input  3  0=R, 1=I, 2=S, 3=B, 4=U, 5=J, 6/7 illegal
- opcode  input  7  opcode field
- funct3  input  3  funct3 field (R/I/S/B)
- funct7  input  7  funct7 field (R only)
- rs1, rs2, rd  input  5 each  register indices
- immediate  input  32  full-width signed (U: already shifted, low 12 bits zero)
- out_valid  output  1  FIFO head valid
- out_ready  input  1  consumer accepts head
- out_instruction  output  32  encoded word at FIFO head
- out_error  output  1  head entry failed its checks
- encoded_count  output  16  words delivered, saturating
- error_count  output  16  erroneous words delivered, saturating

## Operation
- Accept when in_valid && in_ready. Encode combinationally and push {word, error} into the FIFO in the same edge.
- Bit layouts (imm = immediate):
  - R: {funct7, rs2, rs1, funct3, rd, opcode}
  - I: {imm[11:0], rs1, funct3, rd, opcode}
  - S: {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}
  - B: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}
  - U: {imm[31:12], rd, opcode}
  - J: {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode}
- Error conditions (any one sets error):
  - I/S: imm[31:11] not all equal.
  - B: imm[31:12] not all equal, or imm[0]=1.
  - J: imm[31:20] not all equal, or imm[0]=1.
  - U: imm[11:0] ≠ 0.
  - format 6/7.
  - opcode[1:0] ≠ 2'b11.
- On error the stored word is 32'h0000_0013 (addi x0,x0,0) and the error bit is 1. Unused fields for a format are ignored.
- FIFO: DEPTH entries, wrap-around read/write pointers, occupancy counter 0..DEPTH.
- in_ready = (occupancy < DEPTH) && !reset. Registered occupancy only, so there is no combinational path from out_ready to in_ready.
- out_valid = (occupancy ≠ 0). out_instruction and out_error show the head entry and are held stable while out_valid && !out_ready.
- Pop on out_valid && out_ready. Counters update on pop only:
  - encoded_count += 1, saturating at 16'hFFFF.
  - error_count += 1 if the popped entry's error bit is set, saturating at 16'hFFFF.
- Simultaneous push and pop (not full): occupancy unchanged, both pointers advance.
- When full, push is blocked even if a pop occurs that cycle.

## Timing
- Reset (async assert, sync release): occupancy=0, both pointers=0, out_valid=0, out_instruction=0, out_error=0, in_ready=0 while reset is high, both counts=0.
- Reset mid-operation discards all FIFO contents. in_ready=1 on the first cycle after release.
- Latency: bundle accepted at edge N → out_valid=1 with that word after edge N (visible in cycle N+1) when the FIFO was empty.
- Throughput: 1 word/cycle sustained while out_ready=1.
- Ordering strictly FIFO.

## Test plan
- Single encodes, out_ready=1:
  - I: opcode 0x13, rd=1, rs1=0, f3=0, imm=5 → 0x00500093, err 0.
  - R: opcode 0x33, rd=3, rs1=1, rs2=2, f3=0, f7=0 → 0x002081B3.
  - S: opcode 0x23, f3=2, rs1=1, rs2=2, imm=8 → 0x0020A423.
- Branch/jump/upper:
  - B: opcode 0x63, rs1=1, rs2=2, f3=0, imm=-4 → 0xFE208EE3.
  - J: opcode 0x6F, rd=1, imm=0x800 → 0x001000EF.
  - U: opcode 0x37, rd=5, imm=0x12345000 → 0x123452B7.
- Errors:
  - I with imm=2048 → 0x00000013, out_error=1, error_count=1.
  - B with imm=3 → error.
  - format 7 → error.
  - U with imm=0x1 → error.
- Backpressure: out_ready=0, offer 3 bundles back to back → first two accepted, in_ready=0 at the third. Raise out_ready → words drain in order, third accepted on the cycle after the first pop, and out_instruction stays stable while stalled.
- Streaming: 100 valid bundles with out_ready=1 → one word per cycle, encoded_count=100; simultaneous push/pop keeps occupancy at 1.
- Reset mid-stream with 2 entries queued → out_valid=0 and counts=0 immediately (asynchronously), in_ready=1 on the first cycle after release, and no stale words appear afterwards.
